// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the helper used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width. It never drops below one bit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single combinational full-subtractor cell: d = a - b - bin, with a borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generate/propagate.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flop.
// Optional macro SERIAL_SUBTRACTOR_SAT_EN: on signed overflow the
// result is saturated to the largest/smallest signed value.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; operands are captured on acceptance
//   ST_SHIFT | one cell step per cycle, WIDTH cycles in total
//   ST_DONE  | one-cycle done pulse; results were registered on entry
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  // {a_msb, b_msb}: the shift registers lose these before the overflow check.
  logic [1:0]       r_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_shift;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;

  full_subtractor u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Final-step detection, the shifted difference, and the overflow flag.
  // The overflow flag uses the bit being produced right now as the result MSB.
  always_comb begin
    w_last  = (r_cnt == CW'(WIDTH - 1));
    w_shift = (r_d_sr >> 1) | {w_d, {(WIDTH-1){1'b0}}};
    w_ovf   = (r_msb[1] != r_msb[0]) && (w_d != r_msb[1]);
  end

  // Result selection: either wrap the result or saturate it on overflow.
`ifdef SERIAL_SUBTRACTOR_SAT_EN
  always_comb begin
    w_result = w_shift;
    if (w_ovf) begin
      w_result = r_msb[1] ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    w_result = w_shift;
  end
`endif

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Registered handshake outputs. They track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
    end
  end

  // Operand capture, serial datapath, and the result registers.
  // The result registers change only on the last shift step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_msb    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_d_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_msb    <= {a[WIDTH-1], b[WIDTH-1]};
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_d_sr   <= w_shift;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_result;
            r_bout <= w_bout;
            r_ovf  <= w_ovf;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_bout;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4). Each step uses an
// expected value worked out by hand.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow_out;
  logic       overflow;

  int n_vec;
  int n_err;
  logic [3:0] prev_d;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is raised in the current cycle (cycle 0). The task returns at
  // cycle 5, which is the done cycle, just after that clock edge.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ed,
                        input logic eb, input logic eo, input string tag);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_held"}, 32'(diff), 32'(prev_d));
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy5"}, 32'(busy), 32'd1);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    prev_d = ed;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    prev_d = 4'h0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 4'h0;
    b      = 4'h0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // 7 - 3 = 4
    run_op(4'b0111, 4'b0011, 4'b0100, 1'b0, 1'b0, "t1");
    @(posedge clk); #1;
    chk("t1_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    // 3 - 7 = -4
    run_op(4'b0011, 4'b0111, 4'b1100, 1'b1, 1'b0, "t2");
    @(posedge clk); #1;
    // -8 - 1: signed overflow
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    run_op(4'b1000, 4'b0001, 4'b1000, 1'b0, 1'b1, "t3");
`else
    run_op(4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, "t3");
`endif
    @(posedge clk); #1;
    // 7 - (-1): signed overflow, unsigned borrow
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    run_op(4'b0111, 4'b1111, 4'b0111, 1'b1, 1'b1, "t4");
`else
    run_op(4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b1, "t4");
`endif
    @(posedge clk); #1;

    // A start raised while busy is ignored.
    a = 4'b0101;
    b = 4'b0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    a = 4'b1111;
    b = 4'b0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_busy3", 32'(busy), 32'd1);
    chk("t5_nodone3", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("t5_nodone4", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_diff", 32'(diff), 32'b0100);
    chk("t5_borrow", 32'(borrow_out), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    prev_d = 4'b0100;
    @(posedge clk); #1;
    chk("t5_pulse", 32'(done), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    // Start raised in the cycle right after done is accepted.
    run_op(4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0, "t5b");
    @(posedge clk); #1;
    chk("t5b_idle", 32'(busy), 32'd0);

    // Reset in the middle of an operation.
    a = 4'b0110;
    b = 4'b0010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6_held", 32'(diff), 32'b1111);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_diff", 32'(diff), 32'd0);
    chk("t6_rst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_d = 4'b0000;
    @(posedge clk); #1;
    chk("t6_idle", 32'(busy), 32'd0);
    run_op(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, "t6b");
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
